pipe_buffer_elastic: RTL and testbench
======================================

// Module: pipe_buffer_elastic
// PURPOSE
// Parametrised inter-stage pipeline buffer; successor to the fixed-width ID/EX and EX/MEM buffers.
// Carries a WIDTH-bit control/data bundle through STAGES register slots with valid/ready backpressure.
// Each slot has a skid register, so no combinational ready path runs across the pipe.
// Synchronous flush squashes in-flight bundles on taken jumps. Bubbles present NOP_VALUE downstream.
// PARAMETERS
// WIDTH      91    bundle width in bits (91 = ID/EX layout, 76 = EX/MEM layout)
// STAGES     1     register slots in series, 1..8 (>1 models multi-cycle memory latency)
// NOP_VALUE  '0    bundle value driven while out_valid=0 (all control bits deasserted)
// PORTS
// clk        in   1                  rising-edge clock
// rst_n      in   1                  asynchronous active-low reset
// in_valid   in   1                  upstream bundle valid
// in_ready   out  1                  buffer can accept; registered
// in_data    in   WIDTH              upstream bundle
// out_valid  out  1                  bundle at head is valid
// out_ready  in   1                  downstream accepts head
// out_data   out  WIDTH              head bundle; NOP_VALUE when out_valid=0
// flush      in   1                  squash every held bundle at next edge
// occupancy  out  $clog2(2*STAGES+1) number of bundles held (main + skid registers)
// BEHAVIOUR
// - Reset (async assert, sync release): all main/skid valids = 0, all data = NOP_VALUE.
//   in_ready = 1, out_valid = 0, out_data = NOP_VALUE, occupancy = 0.
// - Transfers: accept_in = in_valid & in_ready; accept_out = out_valid & out_ready.
// - Latency: a bundle accepted at edge N appears at out_data after edge N+STAGES-1,
//   i.e. it is visible STAGES cycles after it was presented.
// - Throughput: 1 bundle/cycle while out_ready=1.
// - Slot i (0..STAGES-1) behaves as a two-entry skid with states:
//   EMPTY, ONE (main valid), FULL (main + skid valid).
//   - EMPTY -> ONE on upstream push.
//   - ONE, push and no pop -> FULL; ONE, pop and no push -> EMPTY; push and pop -> stays ONE, main reloaded.
//   - FULL, pop -> ONE: skid moves to main. A push is impossible because ready=0.
//   - ready_i = ~skid_valid_i, taken from a register.
// - Ordering: strict FIFO; no bundle is duplicated or dropped except by flush.
// - Flush: at the next edge every valid bit clears and data returns to NOP_VALUE; occupancy = 0.
//   Flush beats a simultaneous accept_in, so the incoming bundle is dropped.
//   A simultaneous accept_out still completes, because downstream already sampled it.
// - occupancy next = occ + accept_in - accept_out; 0 on flush. It never exceeds 2*STAGES.
// - out_data is muxed to NOP_VALUE when out_valid=0, so an unguarded downstream stage executes a NOP.
// - in_data/out_ready X while the matching valid is low must not corrupt state.
// - Reset asserted mid-transfer discards everything immediately; no partial bundle is emitted.
// STRUCTURE
// - pipe_pkg: PIPE_MAX_STAGES=8, IDEX_W=91, EXMEM_W=76, typedef slot_state_e {EMPTY,ONE,FULL}.
// - Sub-module pipe_skid_slot (WIDTH, NOP_VALUE): one skid slot, same handshake ports plus flush.
// - Top: generate-chain of STAGES slots, occupancy counter, NOP output mux.
// - SVA: out_valid & ~out_ready |=> $stable(out_data); occupancy <= 2*STAGES.
// TESTING
// 1 Reset: rst_n=0 mid-stream with 2 bundles held -> out_valid=0, out_data=0, occupancy=0, in_ready=1,
//   all immediately.
// 2 Streaming (WIDTH=91, STAGES=2, out_ready=1): push 16'd127/16'd10 MOV bundle, then ADD 8/7 ->
//   each emerges 2 cycles later, back-to-back, in order.
// 3 Backpressure: out_ready=0, push continuously -> in_ready drops after 4 accepts, occupancy=4;
//   release -> 4 bundles out in order.
// 4 Flush collision: occupancy=3, assert flush with in_valid=1 and a head handshake in the same cycle ->
//   head delivered, next cycle occupancy=0, new bundle never appears.
// 5 Bubble: in_valid low for 1 cycle between SUB and AND -> out_valid=0 and out_data=NOP_VALUE for exactly 1 cycle.
// 6 Random: 10k cycles of random valid/ready/flush, STAGES in {1,3,8} -> scoreboard order and count,
//   assertions pass.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline buffer and its skid slots.
package pipe_pkg;

    localparam int PIPE_MAX_STAGES = 8;
    localparam int IDEX_W          = 91;
    localparam int EXMEM_W         = 76;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One two-entry skid slot: main register plus skid register, ready taken straight from a flop.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = IDEX_W,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    slot_state_e      state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             ready_reg, ready_next;
    logic             push, pop;

    assign push      = in_valid & ready_reg;
    assign pop       = (state_reg != EMPTY) & out_ready;
    assign in_ready  = ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = EMPTY;
            main_next  = NOP_VALUE;
            skid_next  = NOP_VALUE;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_next  = in_data;
                    end else if (push) begin
                        state_next = FULL;
                        skid_next  = in_data;
                    end else if (pop) begin
                        state_next = EMPTY;
                        main_next  = NOP_VALUE;
                    end
                end
                FULL: begin
                    // ready is low here, so only the drain of the skid entry can happen
                    if (pop) begin
                        state_next = ONE;
                        main_next  = skid_reg;
                        skid_next  = NOP_VALUE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = NOP_VALUE;
                    skid_next  = NOP_VALUE;
                end
            endcase
        end
    end

    assign ready_next = (state_next != FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            main_reg  <= NOP_VALUE;
            skid_reg  <= NOP_VALUE;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            ready_reg <= ready_next;
        end
    end

endmodule

// File: rtl/pipe_buffer_elastic.sv
// Elastic pipeline buffer: STAGES skid slots in series, bundle occupancy counter and NOP head mux.
module pipe_buffer_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = IDEX_W,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    input  logic                             flush,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int               OCC_W   = $clog2(2*STAGES+1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2*STAGES);

    logic             chain_valid [STAGES+1];
    logic             chain_ready [STAGES+1];
    logic [WIDTH-1:0] chain_data  [STAGES+1];
    logic [OCC_W-1:0] occ_reg;
    logic             accept_in, accept_out;

    assign chain_valid[0]      = in_valid;
    assign chain_data[0]       = in_data;
    assign chain_ready[STAGES] = out_ready;
    assign in_ready            = chain_ready[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
            pipe_skid_slot #(
                .WIDTH     (WIDTH),
                .NOP_VALUE (NOP_VALUE)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .in_valid  (chain_valid[gi]),
                .in_ready  (chain_ready[gi]),
                .in_data   (chain_data[gi]),
                .out_valid (chain_valid[gi+1]),
                .out_ready (chain_ready[gi+1]),
                .out_data  (chain_data[gi+1])
            );
        end
    endgenerate

    // Slots already park NOP when empty; the mux keeps the guarantee independent of slot internals.
    assign out_valid = chain_valid[STAGES];
    assign out_data  = out_valid ? chain_data[STAGES] : NOP_VALUE;

    assign accept_in  = in_valid & chain_ready[0];
    assign accept_out = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else if (flush) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_reg + OCC_W'(accept_in) - OCC_W'(accept_out);
        end
    end

    assign occupancy = occ_reg;

    a_head_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (occupancy <= OCC_MAX) && (STAGES <= PIPE_MAX_STAGES));

endmodule

// File: tb/tb_pipe_buffer_elastic.sv
// Bench: directed vector table on a 2-stage buffer, then randomized scoreboard runs on 1/3/8 stages.
module tb_pipe_buffer_elastic;

    localparam int W  = 91;
    localparam int NI = 4;

    function automatic int st_of(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 8;
        endcase
    endfunction

    logic         clk;
    logic         rst_n;
    logic         in_valid_a  [NI];
    logic         in_ready_a  [NI];
    logic [W-1:0] in_data_a   [NI];
    logic         out_valid_a [NI];
    logic         out_ready_a [NI];
    logic [W-1:0] out_data_a  [NI];
    logic         flush_a     [NI];
    logic [4:0]   occ_a       [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int S = st_of(gi);
            logic [$clog2(2*S+1)-1:0] occ_w;
            pipe_buffer_elastic #(
                .WIDTH  (W),
                .STAGES (S)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid_a[gi]),
                .in_ready  (in_ready_a[gi]),
                .in_data   (in_data_a[gi]),
                .out_valid (out_valid_a[gi]),
                .out_ready (out_ready_a[gi]),
                .out_data  (out_data_a[gi]),
                .flush     (flush_a[gi]),
                .occupancy (occ_w)
            );
            assign occ_a[gi] = 5'(occ_w);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        return W'({op, a, b});
    endfunction

    typedef struct {
        logic         iv;
        logic [W-1:0] din;
        logic         ordy;
        logic         fl;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic         e_ir;
        int           e_occ;
        string        tag;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input string tag, input logic iv, input logic [W-1:0] din, input logic ordy,
                        input logic fl, input logic e_ov, input logic [W-1:0] e_od, input logic e_ir,
                        input int e_occ);
        vec_t v;
        v.tag = tag; v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ;
        vecs.push_back(v);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            in_valid_a[i]  = 1'b0;
            in_data_a[i]   = '0;
            out_ready_a[i] = 1'b0;
            flush_a[i]     = 1'b0;
        end
    endtask

    // Reference model for random runs: an ordered list of held bundles.
    logic [W-1:0] mq[$];

    task automatic one_step(input int k, input logic iv, input logic [W-1:0] din,
                            input logic ordy, input logic fl);
        logic acc_in, acc_out;
        chk($sformatf("occ[s%0d]", st_of(k)), W'(occ_a[k]), W'(mq.size()));
        if (out_valid_a[k]) begin
            if (mq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL head[s%0d]: got valid %0h expected no bundle", st_of(k), out_data_a[k]);
            end else begin
                chk($sformatf("head[s%0d]", st_of(k)), out_data_a[k], mq[0]);
            end
        end else begin
            chk($sformatf("nop[s%0d]", st_of(k)), out_data_a[k], '0);
        end
        in_valid_a[k]  = iv;
        in_data_a[k]   = din;
        out_ready_a[k] = ordy;
        flush_a[k]     = fl;
        acc_in  = iv & in_ready_a[k];
        acc_out = out_valid_a[k] & ordy;
        if (acc_out && mq.size() != 0) void'(mq.pop_front());
        if (fl) mq.delete();
        else if (acc_in) mq.push_back(din);
    endtask

    task automatic rand_run(input int k, input int ncyc);
        int pv, pr, s, pushes;
        logic [W-1:0] d;
        s = st_of(k);
        mq.delete();
        pushes = 0;
        pv = 70; pr = 60;
        for (int c = 0; c < ncyc; c++) begin
            if (c % 200 == 0) begin
                pv = $urandom_range(20, 100);
                pr = $urandom_range(10, 100);
            end
            d = W'({$urandom(), $urandom(), $urandom()});
            @(negedge clk);
            one_step(k, ($urandom_range(0, 99) < pv), d, ($urandom_range(0, 99) < pr),
                     ($urandom_range(0, 63) == 0));
            if (in_valid_a[k] && in_ready_a[k]) pushes++;
        end
        for (int c = 0; c < 4 * s + 20 && mq.size() != 0; c++) begin
            @(negedge clk);
            one_step(k, 1'b0, '0, 1'b1, 1'b0);
        end
        @(negedge clk);
        n_cmp++;
        if (mq.size() != 0) begin
            n_fail++;
            $display("FAIL drain[s%0d]: got %0d bundles left expected 0", s, mq.size());
        end
        chk($sformatf("drain_occ[s%0d]", s), W'(occ_a[k]), '0);
        chk($sformatf("drain_ov[s%0d]", s), W'(out_valid_a[k]), '0);
        $display("random run STAGES=%0d cycles=%0d accepted=%0d", s, ncyc, pushes);
        idle_all();
    endtask

    logic [W-1:0] b_mov, b_add, b_sub, b_and, b_a, b_b, b_c, b_d, b_e, b_f, b_g, b_h, b_j, b_k, b_l;

    initial begin
        b_mov = mk(8'h01, 16'd127, 16'd10);
        b_add = mk(8'h02, 16'd8, 16'd7);
        b_sub = mk(8'h03, 16'd20, 16'd5);
        b_and = mk(8'h04, 16'hF0F0, 16'h0FF0);
        b_a = mk(8'h10, 16'd1, 16'd2);  b_b = mk(8'h11, 16'd3, 16'd4);
        b_c = mk(8'h12, 16'd5, 16'd6);  b_d = mk(8'h13, 16'd7, 16'd8);
        b_e = mk(8'h14, 16'd9, 16'd9);  b_f = mk(8'h20, 16'd11, 16'd1);
        b_g = mk(8'h21, 16'd12, 16'd2); b_h = mk(8'h22, 16'd13, 16'd3);
        b_j = mk(8'h23, 16'd14, 16'd4); b_k = mk(8'h30, 16'd15, 16'd5);
        b_l = mk(8'h31, 16'd16, 16'd6);

        //   tag       iv    din    ordy  fl    e_ov  e_od   e_ir  e_occ
        addv("mov_in",  1'b1, b_mov, 1'b1, 1'b0, 1'b0, '0,    1'b1, 1);
        addv("add_in",  1'b1, b_add, 1'b1, 1'b0, 1'b1, b_mov, 1'b1, 2);
        addv("str_2",   1'b0, '0,    1'b1, 1'b0, 1'b1, b_add, 1'b1, 1);
        addv("str_3",   1'b0, '0,    1'b1, 1'b0, 1'b0, '0,    1'b1, 0);
        addv("sub_in",  1'b1, b_sub, 1'b1, 1'b0, 1'b0, '0,    1'b1, 1);
        addv("gap",     1'b0, '0,    1'b1, 1'b0, 1'b1, b_sub, 1'b1, 1);
        addv("and_in",  1'b1, b_and, 1'b1, 1'b0, 1'b0, '0,    1'b1, 1);
        addv("bub_3",   1'b0, '0,    1'b1, 1'b0, 1'b1, b_and, 1'b1, 1);
        addv("bub_4",   1'b0, '0,    1'b1, 1'b0, 1'b0, '0,    1'b1, 0);
        addv("bp_a",    1'b1, b_a,   1'b0, 1'b0, 1'b0, '0,    1'b1, 1);
        addv("bp_b",    1'b1, b_b,   1'b0, 1'b0, 1'b1, b_a,   1'b1, 2);
        addv("bp_c",    1'b1, b_c,   1'b0, 1'b0, 1'b1, b_a,   1'b1, 3);
        addv("bp_d",    1'b1, b_d,   1'b0, 1'b0, 1'b1, b_a,   1'b0, 4);
        addv("bp_e",    1'b1, b_e,   1'b0, 1'b0, 1'b1, b_a,   1'b0, 4);
        addv("rel_1",   1'b0, '0,    1'b1, 1'b0, 1'b1, b_b,   1'b0, 3);
        addv("rel_2",   1'b0, '0,    1'b1, 1'b0, 1'b1, b_c,   1'b1, 2);
        addv("rel_3",   1'b0, '0,    1'b1, 1'b0, 1'b1, b_d,   1'b1, 1);
        addv("rel_4",   1'b0, '0,    1'b1, 1'b0, 1'b0, '0,    1'b1, 0);
        addv("fl_f",    1'b1, b_f,   1'b0, 1'b0, 1'b0, '0,    1'b1, 1);
        addv("fl_g",    1'b1, b_g,   1'b0, 1'b0, 1'b1, b_f,   1'b1, 2);
        addv("fl_h",    1'b1, b_h,   1'b0, 1'b0, 1'b1, b_f,   1'b1, 3);
        addv("flush",   1'b1, b_j,   1'b1, 1'b1, 1'b0, '0,    1'b1, 0);
        addv("post_1",  1'b0, '0,    1'b1, 1'b0, 1'b0, '0,    1'b1, 0);
        addv("post_2",  1'b0, '0,    1'b1, 1'b0, 1'b0, '0,    1'b1, 0);

        idle_all();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", W'(out_valid_a[0]), '0);
        chk("rst_od", out_data_a[0], '0);
        chk("rst_ir", W'(in_ready_a[0]), W'(1));
        chk("rst_occ", W'(occ_a[0]), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid_a[0]  = vecs[i].iv;
            in_data_a[0]   = vecs[i].din;
            out_ready_a[0] = vecs[i].ordy;
            flush_a[0]     = vecs[i].fl;
            @(posedge clk);
            #1;
            $display("vec %0d %s: ov=%0b od=%0h ir=%0b occ=%0d", i, vecs[i].tag,
                     out_valid_a[0], out_data_a[0], in_ready_a[0], occ_a[0]);
            chk({vecs[i].tag, "_ov"}, W'(out_valid_a[0]), W'(vecs[i].e_ov));
            chk({vecs[i].tag, "_od"}, out_data_a[0], vecs[i].e_od);
            chk({vecs[i].tag, "_ir"}, W'(in_ready_a[0]), W'(vecs[i].e_ir));
            chk({vecs[i].tag, "_occ"}, W'(occ_a[0]), W'(vecs[i].e_occ));
        end

        // Reset asserted between edges with two bundles held must clear outputs at once.
        @(negedge clk);
        in_valid_a[0] = 1'b1; in_data_a[0] = b_k; out_ready_a[0] = 1'b0; flush_a[0] = 1'b0;
        @(negedge clk);
        in_data_a[0] = b_l;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        chk("pre_rst_occ", W'(occ_a[0]), W'(2));
        chk("pre_rst_od", out_data_a[0], b_k);
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid-stream reset: ov=%0b od=%0h ir=%0b occ=%0d",
                 out_valid_a[0], out_data_a[0], in_ready_a[0], occ_a[0]);
        chk("mrst_ov", W'(out_valid_a[0]), '0);
        chk("mrst_od", out_data_a[0], '0);
        chk("mrst_ir", W'(in_ready_a[0]), W'(1));
        chk("mrst_occ", W'(occ_a[0]), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_all();
        @(negedge clk);
        chk("post_rst_ov", W'(out_valid_a[0]), '0);

        rand_run(1, 3400);
        rand_run(2, 3400);
        rand_run(3, 3400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
